// File: rtl/mono_hit_builder.sv
// Reassembles the three-word MONOPIX hit record from the RX FIFO into one parallel hit
// with ToT, checking word order and source ID, and presents it on a valid/ready port.
module mono_hit_builder #(
  parameter logic [1:0] IDENTYFIER = 2'd0
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST,
  input  logic        FIFO_EMPTY,
  input  logic [31:0] FIFO_DATA,
  output logic        FIFO_READ,
  input  logic        CONF_DROP_NOISE,
  output logic        HIT_VALID,
  input  logic        HIT_READY,
  output logic [51:0] HIT_TS,
  output logic [5:0]  HIT_COL,
  output logic [7:0]  HIT_ROW,
  output logic [7:0]  HIT_LE,
  output logic [7:0]  HIT_TE,
  output logic [7:0]  HIT_TOT,
  output logic        HIT_NOISE,
  output logic [31:0] HIT_CNT,
  output logic [7:0]  ERR_CNT
);

  typedef enum logic [1:0] {IDLE, GOT0, GOT1} state_t;

  state_t      state, state_nxt;
  logic [27:0] ts_hi_q;
  logic [11:0] ts_mid_q;
  logic [7:0]  le_q, te_q;
  logic [1:0]  tag;
  logic        id_ok, err, cap_w0, cap_w1, complete, load;
  logic        unused_bit7;

  assign tag         = FIFO_DATA[29:28];
  assign id_ok       = (FIFO_DATA[31:30] == IDENTYFIER);
  assign unused_bit7 = FIFO_DATA[7];

  // Stop popping while a hit is stalled so the W2 of the next record cannot overwrite it.
  assign FIFO_READ = !BUS_RST && !FIFO_EMPTY && !(HIT_VALID && !HIT_READY);

  always_comb begin
    state_nxt = state;
    err       = 1'b0;
    cap_w0    = 1'b0;
    cap_w1    = 1'b0;
    complete  = 1'b0;
    if (FIFO_READ) begin
      if (!id_ok) begin
        err = 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (tag == 2'b11) begin
              cap_w0    = 1'b1;
              state_nxt = GOT0;
            end else begin
              err = 1'b1;
            end
          end
          GOT0: begin
            if (tag == 2'b10) begin
              cap_w1    = 1'b1;
              state_nxt = GOT1;
            end else if (tag == 2'b11) begin
              err    = 1'b1;
              cap_w0 = 1'b1;
            end else begin
              err       = 1'b1;
              state_nxt = IDLE;
            end
          end
          GOT1: begin
            if (tag == 2'b01) begin
              complete  = 1'b1;
              state_nxt = IDLE;
            end else if (tag == 2'b11) begin
              err       = 1'b1;
              cap_w0    = 1'b1;
              state_nxt = GOT0;
            end else begin
              err       = 1'b1;
              state_nxt = IDLE;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  assign load = complete && !(CONF_DROP_NOISE && FIFO_DATA[6]);

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state    <= IDLE;
      ts_hi_q  <= '0;
      ts_mid_q <= '0;
      le_q     <= '0;
      te_q     <= '0;
    end else begin
      state <= state_nxt;
      if (cap_w0) ts_hi_q <= FIFO_DATA[27:0];
      if (cap_w1) begin
        ts_mid_q <= FIFO_DATA[27:16];
        le_q     <= FIFO_DATA[15:8];
        te_q     <= FIFO_DATA[7:0];
      end
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      HIT_VALID <= 1'b0;
      HIT_TS    <= '0;
      HIT_COL   <= '0;
      HIT_ROW   <= '0;
      HIT_LE    <= '0;
      HIT_TE    <= '0;
      HIT_TOT   <= '0;
      HIT_NOISE <= 1'b0;
      HIT_CNT   <= '0;
      ERR_CNT   <= '0;
    end else begin
      if (load) begin
        HIT_VALID <= 1'b1;
        HIT_TS    <= {ts_hi_q, ts_mid_q, FIFO_DATA[27:16]};
        HIT_ROW   <= FIFO_DATA[15:8];
        HIT_NOISE <= FIFO_DATA[6];
        HIT_COL   <= FIFO_DATA[5:0];
        HIT_LE    <= le_q;
        HIT_TE    <= te_q;
        HIT_TOT   <= te_q - le_q;
      end else if (HIT_READY) begin
        HIT_VALID <= 1'b0;
      end
      if (HIT_VALID && HIT_READY) HIT_CNT <= HIT_CNT + 32'd1;
      if (err && (ERR_CNT != '1)) ERR_CNT <= ERR_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_mono_hit_builder.sv
// Directed bench for mono_hit_builder: a queue-backed FWFT FIFO feeds words, a monitor
// records every handshake, and one linear sequence checks against hand-computed values.
module tb_mono_hit_builder;

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST;
  logic        FIFO_EMPTY;
  logic [31:0] FIFO_DATA;
  logic        FIFO_READ;
  logic        CONF_DROP_NOISE;
  logic        HIT_VALID;
  logic        HIT_READY;
  logic [51:0] HIT_TS;
  logic [5:0]  HIT_COL;
  logic [7:0]  HIT_ROW, HIT_LE, HIT_TE, HIT_TOT;
  logic        HIT_NOISE;
  logic [31:0] HIT_CNT;
  logic [7:0]  ERR_CNT;

  typedef struct packed {
    logic [51:0] ts;
    logic [5:0]  col;
    logic [7:0]  row;
    logic [7:0]  le;
    logic [7:0]  te;
    logic [7:0]  tot;
    logic        noise;
  } hit_t;

  logic [31:0] fifo_q[$];
  hit_t        recv[$];
  logic        pop_pending = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  mono_hit_builder #(.IDENTYFIER(2'd0)) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST),
    .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA), .FIFO_READ(FIFO_READ),
    .CONF_DROP_NOISE(CONF_DROP_NOISE),
    .HIT_VALID(HIT_VALID), .HIT_READY(HIT_READY),
    .HIT_TS(HIT_TS), .HIT_COL(HIT_COL), .HIT_ROW(HIT_ROW),
    .HIT_LE(HIT_LE), .HIT_TE(HIT_TE), .HIT_TOT(HIT_TOT), .HIT_NOISE(HIT_NOISE),
    .HIT_CNT(HIT_CNT), .ERR_CNT(ERR_CNT)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  // FWFT FIFO: a pop decided just before a rising edge takes effect at the following falling edge.
  initial begin
    FIFO_EMPTY = 1'b1;
    FIFO_DATA  = '0;
    forever begin
      @(negedge BUS_CLK);
      if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
      FIFO_EMPTY = (fifo_q.size() == 0);
      FIFO_DATA  = FIFO_EMPTY ? 32'h0 : fifo_q[0];
      #4 pop_pending = FIFO_READ;
    end
  end

  initial begin
    forever begin
      @(negedge BUS_CLK);
      #4;
      if (HIT_VALID === 1'b1 && HIT_READY === 1'b1)
        recv.push_back('{HIT_TS, HIT_COL, HIT_ROW, HIT_LE, HIT_TE, HIT_TOT, HIT_NOISE});
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge BUS_CLK);
  endtask

  task automatic wait_hits(input int n);
    for (int i = 0; i < 200 && recv.size() < n; i++) @(negedge BUS_CLK);
    check("hit_count", 64'(recv.size()), 64'(n));
  endtask

  task automatic wait_drained();
    for (int i = 0; i < 200 && fifo_q.size() != 0; i++) @(negedge BUS_CLK);
    check("fifo_drained", 64'(fifo_q.size()), 64'd0);
    cycles(3);
  endtask

  task automatic push_hit(input logic [27:0] hi, input logic [11:0] mid, input logic [11:0] lo,
                          input logic [7:0] le, input logic [7:0] te, input logic [7:0] row,
                          input logic [5:0] col, input logic noise);
    fifo_q.push_back({2'b00, 2'b11, hi});
    fifo_q.push_back({2'b00, 2'b10, mid, le, te});
    fifo_q.push_back({2'b00, 2'b01, lo, row, 1'b0, noise, col});
  endtask

  initial begin
    BUS_RST = 1'b1;
    CONF_DROP_NOISE = 1'b0;
    HIT_READY = 1'b1;
    cycles(3);
    check("rst_fifo_read", 64'(FIFO_READ), 64'd0);
    check("rst_valid", 64'(HIT_VALID), 64'd0);
    check("rst_ts", 64'(HIT_TS), 64'd0);
    check("rst_tot", 64'(HIT_TOT), 64'd0);
    check("rst_hit_cnt", 64'(HIT_CNT), 64'd0);
    check("rst_err_cnt", 64'(ERR_CNT), 64'd0);
    BUS_RST = 1'b0;
    cycles(2);

    // Clean hit from literal words
    fifo_q.push_back(32'h3ABCDEF0);
    fifo_q.push_back(32'h2123050A);
    fifo_q.push_back(32'h14560A05);
    wait_hits(1);
    check("clean_ts", 64'(recv[0].ts), 64'h000ABCDEF0123456);
    check("clean_le", 64'(recv[0].le), 64'h05);
    check("clean_te", 64'(recv[0].te), 64'h0A);
    check("clean_tot", 64'(recv[0].tot), 64'd5);
    check("clean_row", 64'(recv[0].row), 64'h0A);
    check("clean_col", 64'(recv[0].col), 64'd5);
    check("clean_noise", 64'(recv[0].noise), 64'd0);
    check("clean_hit_cnt", 64'(HIT_CNT), 64'd1);
    check("clean_err_cnt", 64'(ERR_CNT), 64'd0);
    check("clean_valid_clr", 64'(HIT_VALID), 64'd0);

    // Backpressure: three records queued while the consumer stalls
    HIT_READY = 1'b0;
    push_hit(28'h1111111, 12'h222, 12'h333, 8'h10, 8'h30, 8'h01, 6'h01, 1'b0);
    push_hit(28'h2222222, 12'h444, 12'h555, 8'h40, 8'h45, 8'h02, 6'h02, 1'b0);
    push_hit(28'h3333333, 12'h666, 12'h777, 8'h80, 8'h7F, 8'h03, 6'h3F, 1'b0);
    cycles(8);
    for (int i = 0; i < 12; i++) begin
      check("bp_valid", 64'(HIT_VALID), 64'd1);
      check("bp_fifo_read", 64'(FIFO_READ), 64'd0);
      check("bp_ts_stable", 64'(HIT_TS), 64'h0001111111222333);
      cycles(1);
    end
    check("bp_fifo_left", 64'(fifo_q.size()), 64'd6);
    check("bp_hit_cnt", 64'(HIT_CNT), 64'd1);
    HIT_READY = 1'b1;
    wait_hits(4);
    check("bp_ts_a", 64'(recv[1].ts), 64'h0001111111222333);
    check("bp_tot_a", 64'(recv[1].tot), 64'h20);
    check("bp_ts_b", 64'(recv[2].ts), 64'h0002222222444555);
    check("bp_tot_b", 64'(recv[2].tot), 64'h05);
    check("bp_ts_c", 64'(recv[3].ts), 64'h0003333333666777);
    check("bp_tot_c", 64'(recv[3].tot), 64'hFF);
    check("bp_col_c", 64'(recv[3].col), 64'h3F);
    cycles(2);
    check("bp_hit_cnt_end", 64'(HIT_CNT), 64'd4);

    // Sequence errors: stale W0 replaced by a new W0, then a lone W1
    fifo_q.push_back(32'h30DEAD00);
    push_hit(28'h4444444, 12'h888, 12'h999, 8'h01, 8'h02, 8'h04, 6'h04, 1'b0);
    wait_hits(5);
    check("seq_ts", 64'(recv[4].ts), 64'h0004444444888999);
    check("seq_err1", 64'(ERR_CNT), 64'd1);
    fifo_q.push_back(32'h20000102);
    wait_drained();
    check("seq_err2", 64'(ERR_CNT), 64'd2);
    check("seq_no_hit", 64'(recv.size()), 64'd5);

    // Noise filter
    CONF_DROP_NOISE = 1'b1;
    push_hit(28'h5555555, 12'hAAA, 12'hBBB, 8'h00, 8'h09, 8'h05, 6'h06, 1'b1);
    wait_drained();
    check("noise_drop_valid", 64'(HIT_VALID), 64'd0);
    check("noise_drop_cnt", 64'(HIT_CNT), 64'd5);
    check("noise_drop_recv", 64'(recv.size()), 64'd5);
    CONF_DROP_NOISE = 1'b0;
    push_hit(28'h5555555, 12'hAAA, 12'hBBB, 8'h00, 8'h09, 8'h05, 6'h06, 1'b1);
    wait_hits(6);
    check("noise_keep_flag", 64'(recv[5].noise), 64'd1);
    check("noise_keep_ts", 64'(recv[5].ts), 64'h0005555555AAABBBB >> 4);
    check("noise_keep_tot", 64'(recv[5].tot), 64'd9);
    check("noise_err_cnt", 64'(ERR_CNT), 64'd2);

    // Reset after W1 discards the partial record and clears counters
    fifo_q.push_back(32'h37777777);
    fifo_q.push_back(32'h2AAA1122);
    wait_drained();
    BUS_RST = 1'b1;
    cycles(2);
    check("mid_rst_fifo_read", 64'(FIFO_READ), 64'd0);
    BUS_RST = 1'b0;
    cycles(1);
    check("mid_rst_valid", 64'(HIT_VALID), 64'd0);
    check("mid_rst_hit_cnt", 64'(HIT_CNT), 64'd0);
    check("mid_rst_err_cnt", 64'(ERR_CNT), 64'd0);
    check("mid_rst_ts", 64'(HIT_TS), 64'd0);

    // Foreign-ID word between W0 and W1, with ToT wrapping past 255
    fifo_q.push_back(32'h36666666);
    fifo_q.push_back(32'hA0000000);
    fifo_q.push_back(32'h2CCCFA03);
    fifo_q.push_back(32'h1DDD7F2A);
    wait_hits(7);
    check("id_ts", 64'(recv[6].ts), 64'h0006666666CCCDDD);
    check("id_le", 64'(recv[6].le), 64'hFA);
    check("id_te", 64'(recv[6].te), 64'h03);
    check("id_tot", 64'(recv[6].tot), 64'd9);
    check("id_row", 64'(recv[6].row), 64'h7F);
    check("id_col", 64'(recv[6].col), 64'h2A);
    cycles(2);
    check("id_err_cnt", 64'(ERR_CNT), 64'd1);
    check("id_hit_cnt", 64'(HIT_CNT), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
